serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder built around a single one-bit full-adder cell (sum = A^B^Ci, carry = majority) plus a carry flip-flop. It is the sequential stage downstream of the combinational full-adder logic. Each accepted operation processes one bit per clock, LSB first. It loads two parallel operands on a start pulse and reports a registered sum, carry-out and a one-cycle done pulse.

---
 rtl/serial_adder.sv | 114 +++++++++++
 tb/tb_serial_adder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Optional subtract mode is enabled with the SERIAL_ADDER_SUB_EN macro.
//
// state | meaning
// IDLE  | waiting for start; sum/co hold the last result
// CALC  | one operand bit per clock, WIDTH clocks per operation
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-2:0] acc_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             co_q;

    logic             s_d;
    logic             carry_d;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    always_comb begin
        s_d     = a_q[0] ^ b_q[0] ^ carry_q;
        carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        acc_d   = {s_d, acc_q};
    end

    // Subtraction is a + ~b + 1; co then reads as "no borrow".
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        b_load     = sub ? ~b : b;
        carry_load = sub ? 1'b1 : ci;
`else
        b_load     = b;
        carry_load = ci;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            co_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b_load;
                        carry_q <= carry_load;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    carry_q <= carry_d;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    acc_q   <= acc_d[WIDTH-1:1];
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        sum_q   <= acc_d;
                        co_q    <= carry_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign co   = co_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sub_s;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         co;

    int vectors    = 0;
    int miscompares = 0;

    logic [W-1:0] exp_sum;
    logic         exp_co;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub_s),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci,
                         input logic tsub, output logic [W-1:0] rs, output logic rc);
        int unsigned total;
        if (tsub) begin
            rs = W'((int'(ta) - int'(tb)) & ((1 << W) - 1));
            rc = (ta >= tb);
        end else begin
            total = int'(ta) + int'(tb) + int'(tci);
            rs = W'(total);
            rc = total[W];
        end
    endtask

    // Issues one start pulse, follows the operation to done, checks the result.
    // inj >= 0 pulses start again that many cycles into the operation.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci,
                          input logic tsub, input int inj);
        logic [W-1:0] rs;
        logic         rc;
        int           n;
        model(ta, tb, tci, tsub, rs, rc);
        a = ta; b = tb; ci = tci; sub_s = tsub; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!done && n < 4 * W) begin
            check("busy_while_calc", busy, 1);
            check("sum_held", sum, exp_sum);
            check("co_held", co, exp_co);
            if (n == inj) begin
                start = 1'b1;
                a = W'($urandom);
                b = W'($urandom);
            end
            step();
            start = 1'b0;
            n++;
        end
        check("latency", n, W);
        exp_sum = rs;
        exp_co  = rc;
        check("sum", sum, exp_sum);
        check("co", co, exp_co);
        check("busy_at_done", busy, 0);
        step();
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        logic tsub;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0; sub_s = 1'b0;
        exp_sum = '0; exp_co = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_co", co, 0);
        step(); step();
        rst_n = 1'b1;
        step();
        check("idle_no_done", done, 0);

        run_op(8'hFF, 8'h01, 1'b0, 1'b0, -1);
        run_op(8'h5A, 8'h3C, 1'b1, 1'b0, -1);
        check("cin_sum_value", sum, 8'h97);
        a = 8'h12; b = 8'h34; ci = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("sum_stable_idle", sum, 8'h97);
            check("busy_idle", busy, 0);
        end

        run_op(8'h01, 8'h02, 1'b0, 1'b0, 3);
        check("ignored_start_sum", sum, 8'h03);
        for (int i = 0; i < W + 3; i++) begin
            check("no_second_done", done, 0);
            check("no_second_busy", busy, 0);
            step();
        end

        a = 8'hF0; b = 8'h0F; ci = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        #1;
        exp_sum = '0; exp_co = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_co", co, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            step();
            check("abort_no_done", done, 0);
        end
        run_op(8'hF0, 8'h0F, 1'b1, 1'b0, -1);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, -1);
        check("sub_sum_0f", sum, 8'h0F);
        check("sub_co_1", co, 1);
        run_op(8'h00, 8'h01, 1'b1, 1'b1, -1);
        check("sub_sum_ff", sum, 8'hFF);
        check("sub_co_0", co, 0);
`endif

        for (int i = 0; i < 25; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
            tsub = 1'($urandom);
`else
            tsub = 1'b0;
`endif
            run_op(W'($urandom), W'($urandom), 1'($urandom), tsub, -1);
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
